zero_scan_unit: RTL
===================

ZERO_SCAN_UNIT -- requirements
Module: zero_scan_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits.
REQ-002 SHALL have parameter CHUNK, default 8, bits examined per scan cycle; WIDTH SHALL be an integer multiple of CHUNK; NCHUNK = WIDTH/CHUNK.
REQ-003 SHALL have parameter EARLY_EXIT, default 1, enabling scan termination at the first deciding chunk.
REQ-004 SHALL have port clock  input  1  sole clock, all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  request; accepted only on a rising edge where ready=1.
REQ-007 SHALL have port mode  input  2  operation: 00 zero-test A, 01 equality A==B, 10 leading-zero count of A, 11 treated as 00.
REQ-008 SHALL have port dataA  input  WIDTH  operand A, sampled at accept.
REQ-009 SHALL have port dataB  input  WIDTH  operand B, sampled at accept (used by mode 01 only).
REQ-010 SHALL have port ready  output  1  high in IDLE only.
REQ-011 SHALL have port busy  output  1  high in SCAN and DONE.
REQ-012 SHALL have port done  output  1  one-cycle pulse when a result is updated.
REQ-013 SHALL have port isZero  output  1  result of mode 00/11 (1 = A all zeros).
REQ-014 SHALL have port isEqual  output  1  result of mode 01 (1 = A equals B).
REQ-015 SHALL have port lzCount  output  clog2(WIDTH)+1  result of mode 10, range 0..WIDTH.

Function
REQ-016 SHALL implement FSM IDLE -> SCAN on accepted start; SCAN -> DONE after last scanned chunk; DONE -> IDLE unconditionally after one cycle.
REQ-017 At accept SHALL latch dataA, dataB, mode into internal registers; later input changes SHALL NOT affect the operation.
REQ-018 SCAN SHALL process exactly one CHUNK-bit slice per cycle, MSB slice (index NCHUNK-1) first, descending index.
REQ-019 Mode 00: accumulate AND of (sliceA == 0); with EARLY_EXIT=1 terminate on the first nonzero slice.
REQ-020 Mode 01: accumulate AND of (sliceA == sliceB); with EARLY_EXIT=1 terminate on the first mismatching slice.
REQ-021 Mode 10: add CHUNK per all-zero slice; on the first nonzero slice add its leading-zero count and terminate (regardless of EARLY_EXIT); all-zero A yields lzCount = WIDTH.
REQ-022 With EARLY_EXIT=0 modes 00/01 SHALL always scan all NCHUNK slices.
REQ-023 With k = slices scanned (1..NCHUNK), done SHALL be high for exactly one cycle, k+1 cycles after the accepting edge.
REQ-024 Only the result output selected by the latched mode SHALL update, on the edge that raises done; the other two result outputs SHALL hold.
REQ-025 Result outputs SHALL hold stable from done until the next done.
REQ-026 start while busy=1 (SCAN or DONE) SHALL be ignored with no queuing.
REQ-027 start held high continuously SHALL be re-accepted on the first edge back in IDLE, giving back-to-back operations with one idle cycle between done and the next accept.

Reset
REQ-028 reset assertion SHALL immediately force state IDLE, ready=1, busy=0, done=0, isZero=0, isEqual=0, lzCount=0, clear all latched operands and slice index, independent of clock.
REQ-029 reset asserted mid-SCAN or in DONE SHALL abort the operation with no done pulse; first accept is possible on the first rising edge after reset deasserts.

Verification
REQ-030 WIDTH=32, CHUNK=8: mode 00, A=0x00000000 -> k=4, done 5 cycles after accept, isZero=1.
REQ-031 Mode 00, A=0x80000000, EARLY_EXIT=1 -> k=1, done 2 cycles after accept, isZero=0; EARLY_EXIT=0 -> done 5 cycles after accept, isZero=0.
REQ-032 Mode 10, A=0x00001000 -> k=3, done 4 cycles after accept, lzCount=19; A=0 -> lzCount=32, k=4; isZero/isEqual unchanged.
REQ-033 Mode 01, A=B=0xDEADBEEF -> isEqual=1, k=4; A=0xDEADBEEF, B=0xDEADBEEE -> isEqual=0, k=4; A=0x1EADBEEF, B=0xDEADBEEF -> isEqual=0, k=1.
REQ-034 Pulse start and change dataA during SCAN -> start ignored, busy stays 1, result reflects originally latched A, exactly one done.
REQ-035 Assert reset 2 cycles into a mode-00 scan of A=0 -> outputs at reset values immediately, no done; new start after release completes normally with isZero=1.

Source files
------------

// File: rtl/zero_scan_unit_if.sv
// zero_scan_unit_if: request/result bundle between a requester and the zero scan unit
interface zero_scan_unit_if #(parameter int WIDTH = 32) ();
  logic start;
  logic [1:0] mode;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic ready;
  logic busy;
  logic done;
  logic isZero;
  logic isEqual;
  logic [$clog2(WIDTH):0] lzCount;
  modport master (output start, mode, dataA, dataB, input ready, busy, done, isZero, isEqual, lzCount);
  modport slave (input start, mode, dataA, dataB, output ready, busy, done, isZero, isEqual, lzCount);
endinterface

// File: rtl/zero_scan_unit.sv
// zero_scan_unit: chunk-serial zero test, equality compare and leading-zero count
module zero_scan_unit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int EARLY_EXIT = 1
) (
  input logic clock,
  input logic reset,
  zero_scan_unit_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  localparam int LW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0] op;
  logic [IW-1:0] idx;
  logic flag;
  logic [LW-1:0] cnt;
  logic [CHUNK-1:0] sa;
  logic [CHUNK-1:0] sb;
  logic zero;
  logic hit;
  logic stop;
  logic [LW-1:0] add;
  // leading zeros of one slice; an all-zero slice counts as a full CHUNK
  function automatic logic [LW-1:0] lzc(input logic [CHUNK-1:0] s);
    lzc = LW'(CHUNK);
    for (int i = 0; i < CHUNK; i++) if (s[i]) lzc = LW'(CHUNK - 1 - i);
  endfunction
  // current slice evaluation and the decision whether this is the final slice
  always_comb begin
    sa = CHUNK'(a >> (CHUNK * idx));
    sb = CHUNK'(b >> (CHUNK * idx));
    zero = sa == '0;
    hit = op == 2'b01 ? sa == sb : zero;
    add = lzc(sa);
    stop = idx == '0 || (op == 2'b10 ? !zero : (EARLY_EXIT != 0 && !hit));
  end
  // control FSM with registered status and result outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      bus.ready <= 1'b1;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.isZero <= 1'b0;
      bus.isEqual <= 1'b0;
      bus.lzCount <= '0;
      a <= '0;
      b <= '0;
      op <= '0;
      idx <= '0;
      flag <= 1'b0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            a <= bus.dataA;
            b <= bus.dataB;
            op <= bus.mode;
            idx <= IW'(NCHUNK - 1);
            flag <= 1'b1;
            cnt <= '0;
            state <= SCAN;
            bus.ready <= 1'b0;
            bus.busy <= 1'b1;
          end
        end
        SCAN: begin
          flag <= flag & hit;
          cnt <= cnt + add;
          idx <= idx - 1'b1;
          if (stop) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
          bus.ready <= 1'b1;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
          if (op == 2'b01) bus.isEqual <= flag;
          else if (op == 2'b10) bus.lzCount <= cnt;
          else bus.isZero <= flag;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
